// File: rtl/tensor_core_instruction_sequencer.sv
// ---------------------------------------------------------------------------
// tensor_core_instruction_sequencer
//
// Buffers host instruction words in a small FIFO and issues them one per
// cycle to the tensor core controller. Operate instructions are followed by a
// fixed number of NOP cycles. Burst headers are followed by a fixed number of
// data beats: write bursts pass the next FIFO words through verbatim, and read
// bursts emit NOPs while the core returns data.
//
// Parameters
//   FIFO_DEPTH   instruction FIFO depth in words (power of two, >= 2)
//   BURST_BEATS  data beats that follow a burst header (>= 1)
//   OPERATE_GAP  NOP cycles inserted after each operate instruction
//
// Ports
//   clock_in                 single rising-edge clock
//   reset_in                 synchronous active-high reset
//   instr_valid_in           host word on instr_data_in is valid
//   instr_data_in[15:0]      host instruction or burst data word
//   instr_ready_out          FIFO can accept a word (not full)
//   enable_in                permits new instruction issue from ISSUE state
//   current_instruction_out  registered instruction to the core controller
//   busy_out                 sequence in progress or words still queued
//   underrun_error_out       sticky: a write burst ran out of data words
//   illegal_error_out        sticky: a burst used the reserved select 11
//   fifo_count_out           current FIFO occupancy
// ---------------------------------------------------------------------------
module tensor_core_instruction_sequencer #(
    parameter int FIFO_DEPTH  = 8,
    parameter int BURST_BEATS = 5,
    parameter int OPERATE_GAP = 2
) (
    input  logic                          clock_in,
    input  logic                          reset_in,
    input  logic                          instr_valid_in,
    input  logic [15:0]                   instr_data_in,
    output logic                          instr_ready_out,
    input  logic                          enable_in,
    output logic [15:0]                   current_instruction_out,
    output logic                          busy_out,
    output logic                          underrun_error_out,
    output logic                          illegal_error_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int FCNT_W  = PTR_W + 1;
    localparam int CNT_MAX = (BURST_BEATS > OPERATE_GAP) ? BURST_BEATS : OPERATE_GAP;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_ISSUE    = 2'd0,
        ST_BURST_WR = 2'd1,
        ST_BURST_RD = 2'd2,
        ST_GAP      = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Instruction FIFO
    // ------------------------------------------------------------------
    logic [15:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [FCNT_W-1:0] fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic [15:0]       fifo_head;

    assign fifo_full       = (fifo_count == FCNT_W'(FIFO_DEPTH));
    assign fifo_empty      = (fifo_count == '0);
    assign push            = instr_valid_in && !fifo_full;
    assign fifo_head       = fifo_mem[rd_ptr];
    assign instr_ready_out = !fifo_full;
    assign fifo_count_out  = fifo_count;

    // Storage needs no reset; the pointers alone define what is valid.
    always_ff @(posedge clock_in) begin
        if (push) begin
            fifo_mem[wr_ptr] <= instr_data_in;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Issue FSM
    // ------------------------------------------------------------------
    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] beat_cnt_next;
    logic [15:0]      instr_next;
    logic             underrun_next;
    logic             illegal_next;

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state                   <= ST_ISSUE;
            beat_cnt                <= '0;
            current_instruction_out <= 16'h0000;
            underrun_error_out      <= 1'b0;
            illegal_error_out       <= 1'b0;
        end else begin
            state                   <= state_next;
            beat_cnt                <= beat_cnt_next;
            current_instruction_out <= instr_next;
            underrun_error_out      <= underrun_next;
            illegal_error_out       <= illegal_next;
        end
    end

    always_comb begin
        state_next    = state;
        beat_cnt_next = beat_cnt;
        instr_next    = 16'h0000;
        pop           = 1'b0;
        underrun_next = underrun_error_out;
        illegal_next  = illegal_error_out;

        case (state)
            ST_ISSUE: begin
                if (enable_in && !fifo_empty) begin
                    pop        = 1'b1;
                    instr_next = fifo_head;
                    case (fifo_head[1:0])
                        2'b10: begin
                            case (fifo_head[3:2])
                                2'b11: begin
                                    // Reserved select: squash the word, keep issuing.
                                    instr_next   = 16'h0000;
                                    illegal_next = 1'b1;
                                end
                                2'b00: begin
                                    state_next    = ST_BURST_RD;
                                    beat_cnt_next = CNT_W'(BURST_BEATS);
                                end
                                default: begin
                                    state_next    = ST_BURST_WR;
                                    beat_cnt_next = CNT_W'(BURST_BEATS);
                                end
                            endcase
                        end
                        2'b01: begin
                            if (OPERATE_GAP > 0) begin
                                state_next    = ST_GAP;
                                beat_cnt_next = CNT_W'(OPERATE_GAP);
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end

            ST_BURST_WR: begin
                // Data beats bypass decode and ignore enable_in; a missing
                // word still burns its beat so the burst length is fixed.
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    instr_next = fifo_head;
                end else begin
                    underrun_next = 1'b1;
                end
                beat_cnt_next = beat_cnt - 1'b1;
                if (beat_cnt <= CNT_W'(1)) begin
                    state_next = ST_ISSUE;
                end
            end

            default: begin
                // BURST_RD and GAP both emit NOPs and leave the FIFO alone.
                beat_cnt_next = beat_cnt - 1'b1;
                if (beat_cnt <= CNT_W'(1)) begin
                    state_next = ST_ISSUE;
                end
            end
        endcase
    end

    assign busy_out = (state != ST_ISSUE) || !fifo_empty;

endmodule
